mmio_responder: RTL and testbench

Memory-mapped peripheral that answers the processor's data-memory port for a reserved address window, returning read data on `q_dmem` and absorbing stores. It provides a free-running cycle counter, a one-shot down-timer with sticky status, and a FIFO-buffered 8N1 serial transmitter. It sits beside the data RAM in the wrapper; the wrapper muxes `q_dmem` from this block whenever `sel` is high.

---
 rtl/mmio_pkg.sv | 24 ++
 rtl/tx_fifo.sv | 52 +++++
 rtl/mmio_responder.sv | 170 +++++++++++++++++
 tb/tb_mmio_responder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the MMIO responder: register offsets, STATUS bit
// positions and the serial transmitter state encoding.
package mmio_pkg;

    localparam logic [3:0] OFF_CYCLE  = 4'd0;
    localparam logic [3:0] OFF_TIMER  = 4'd1;
    localparam logic [3:0] OFF_STATUS = 4'd2;
    localparam logic [3:0] OFF_TXDATA = 4'd3;

    localparam int ST_TIMER_DONE = 0;
    localparam int ST_FULL       = 1;
    localparam int ST_EMPTY      = 2;
    localparam int ST_TX_ACTIVE  = 3;
    localparam int ST_COUNT_LSB  = 4;
    localparam int ST_OVERFLOW   = 8;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO feeding the serial transmitter. A push on a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module tx_fifo #(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_count;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign full      = (r_count == (AW+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign dout      = r_mem[r_rd];
    assign w_pop_ok  = pop & ~empty;
    assign w_push_ok = push & (~full | w_pop_ok);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + AW'(1);
            if (w_pop_ok)  r_rd <= r_rd + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_push_ok) r_mem[r_wr] <= din;
    end

endmodule

// File: rtl/mmio_responder.sv
// Data-memory window peripheral: cycle counter, one-shot down-timer with
// sticky done flag, and a FIFO-buffered 8N1 serial transmitter.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h0000_1000,
    parameter int          FIFO_DEPTH = 8,
    parameter int          BAUD_DIV   = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic        sel,
    output logic        tx,
    output logic        tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(BAUD_DIV);

    logic [31:0]   r_cycle;
    logic [31:0]   r_timer;
    logic          r_timer_done;
    logic          r_tx_ovf;
    tx_state_t     r_state;
    tx_state_t     w_state_n;
    logic [BW-1:0] r_baud;
    logic [BW-1:0] w_baud_n;
    logic [2:0]    r_bit;
    logic [2:0]    w_bit_n;
    logic [7:0]    r_shift;
    logic [7:0]    w_shift_n;

    logic [3:0]    w_off;
    logic          w_wr_timer;
    logic          w_wr_status;
    logic          w_wr_tx;
    logic          w_timer_fire;
    logic          w_ovf_set;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_dout;
    logic          w_baud_end;
    logic [31:0]   w_status;

    assign sel         = (address_dmem[31:4] == BASE_ADDR[31:4]);
    assign w_off       = address_dmem[3:0];
    assign w_wr_timer  = wren & sel & (w_off == OFF_TIMER);
    assign w_wr_status = wren & sel & (w_off == OFF_STATUS);
    assign w_wr_tx     = wren & sel & (w_off == OFF_TXDATA);

    // A store landing on the 1->0 step replaces the decrement, so no done.
    assign w_timer_fire = (r_timer == 32'd1) & ~w_wr_timer;
    assign w_ovf_set    = w_wr_tx & w_full & ~w_pop;

    tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_wr_tx),
        .pop   (w_pop),
        .din   (data[7:0]),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_cycle      <= '0;
            r_timer      <= '0;
            r_timer_done <= 1'b0;
            r_tx_ovf     <= 1'b0;
        end else begin
            r_cycle <= r_cycle + 32'd1;
            if (w_wr_timer)          r_timer <= data;
            else if (r_timer != '0)  r_timer <= r_timer - 32'd1;
            r_timer_done <= w_timer_fire | (r_timer_done & ~(w_wr_status & data[ST_TIMER_DONE]));
            r_tx_ovf     <= w_ovf_set    | (r_tx_ovf     & ~(w_wr_status & data[ST_OVERFLOW]));
        end
    end

    always_comb begin
        w_status                    = '0;
        w_status[ST_TIMER_DONE]     = r_timer_done;
        w_status[ST_FULL]           = w_full;
        w_status[ST_EMPTY]          = w_empty;
        w_status[ST_TX_ACTIVE]      = (r_state != TX_IDLE);
        w_status[ST_COUNT_LSB +: 4] = 4'(w_count);
        w_status[ST_OVERFLOW]       = r_tx_ovf;
    end

    always_comb begin
        q_dmem = '0;
        if (sel) begin
            case (w_off)
                OFF_CYCLE:  q_dmem = r_cycle;
                OFF_TIMER:  q_dmem = r_timer;
                OFF_STATUS: q_dmem = w_status;
                default:    q_dmem = '0;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= TX_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_n;
            r_baud  <= w_baud_n;
            r_bit   <= w_bit_n;
            r_shift <= w_shift_n;
        end
    end

    assign w_baud_end = (r_baud == BW'(BAUD_DIV - 1));
    assign tx_busy    = (r_state != TX_IDLE) | ~w_empty;

    always_comb begin
        w_state_n = r_state;
        w_baud_n  = r_baud + BW'(1);
        w_bit_n   = r_bit;
        w_shift_n = r_shift;
        w_pop     = 1'b0;
        tx        = 1'b1;
        case (r_state)
            TX_IDLE: begin
                w_baud_n = '0;
                if (!w_empty) begin
                    w_pop     = 1'b1;
                    w_shift_n = w_dout;
                    w_state_n = TX_START;
                end
            end
            TX_START: begin
                tx = 1'b0;
                if (w_baud_end) begin
                    w_state_n = TX_DATA;
                    w_baud_n  = '0;
                    w_bit_n   = '0;
                end
            end
            TX_DATA: begin
                tx = r_shift[0];
                if (w_baud_end) begin
                    w_baud_n  = '0;
                    w_shift_n = {1'b0, r_shift[7:1]};
                    if (r_bit == 3'd7) w_state_n = TX_STOP;
                    else               w_bit_n   = r_bit + 3'd1;
                end
            end
            TX_STOP: begin
                if (w_baud_end) begin
                    w_state_n = TX_IDLE;
                    w_baud_n  = '0;
                end
            end
            default: w_state_n = TX_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed-plus-random bench for mmio_responder: CYCLE, TIMER, STATUS,
// TX framing, FIFO overflow, decode window and asynchronous reset.
module tb_mmio_responder;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          BD    = 4;
    localparam int          DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] address_dmem;
    logic [31:0] data;
    logic        wren;
    logic [31:0] q_dmem;
    logic        sel;
    logic        tx;
    logic        tx_busy;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_cycle = '0;
    logic [7:0]  fifo_q[$];

    mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .BAUD_DIV(BD)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .data         (data),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .sel          (sel),
        .tx           (tx),
        .tx_busy      (tx_busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        model_cycle = model_cycle + 32'd1;
    endtask

    task automatic store_addr(input logic [31:0] addr, input logic [31:0] v);
        address_dmem = addr;
        data         = v;
        wren         = 1'b1;
        tick();
        wren         = 1'b0;
    endtask

    task automatic store(input logic [3:0] off, input logic [31:0] v);
        store_addr(BASE + {28'd0, off}, v);
    endtask

    task automatic rd(input logic [31:0] addr, output logic [31:0] v);
        address_dmem = addr;
        #1;
        v = q_dmem;
    endtask

    function automatic logic [31:0] exp_status(input bit done, input bit ovf, input int cnt, input bit active);
        logic [31:0] s;
        s = '0;
        s[0]   = done;
        s[1]   = (cnt == DEPTH);
        s[2]   = (cnt == 0);
        s[3]   = active;
        s[7:4] = cnt[3:0];
        s[8]   = ovf;
        return s;
    endfunction

    // 8N1 frame: start 0, data LSB first, stop 1
    function automatic logic frame_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    // Entered on the cycle after the pop edge; leaves on the cycle after STOP.
    task automatic check_frame(input logic [7:0] b);
        for (int k = 0; k < 10; k++) begin
            for (int j = 0; j < BD; j++) begin
                check($sformatf("tx_bit%0d", k), {31'd0, tx}, {31'd0, frame_bit(b, k)});
                check("tx_busy_frame", {31'd0, tx_busy}, 32'd1);
                tick();
            end
        end
    endtask

    initial begin
        logic [31:0] v, v2, tv;
        logic [31:0] p;
        logic [7:0]  b, b2;
        bit          ovf_exp;

        reset        = 1'b1;
        wren         = 1'b0;
        data         = '0;
        address_dmem = BASE + 32'd4;
        repeat (3) @(posedge clock);
        #1;
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        reset       = 1'b0;
        model_cycle = '0;

        rd(BASE + 32'd0, v); check("reset_cycle", v, 32'd0);
        rd(BASE + 32'd1, v); check("reset_timer", v, 32'd0);
        rd(BASE + 32'd2, v); check("reset_status", v, exp_status(0, 0, 0, 0));

        // Free-running counter
        repeat (5) tick();
        rd(BASE, v);
        check("cycle_at5", v, model_cycle);
        repeat (4) tick();
        rd(BASE, v2);
        check("cycle_at9", v2, model_cycle);
        check("cycle_delta", v2 - v, 32'd4);
        store(4'd0, 32'h0000_FFFF);
        rd(BASE, v);
        check("cycle_ro", v, model_cycle);

        // Wrap from all-ones
        force dut.r_cycle = 32'hFFFF_FFFF;
        rd(BASE, v);
        check("cycle_forced", v, 32'hFFFF_FFFF);
        release dut.r_cycle;
        model_cycle = 32'hFFFF_FFFF;
        tick();
        rd(BASE, v);
        check("cycle_wrap", v, model_cycle);

        // One-shot timer, first value 3 then random
        for (int r = 0; r < 4; r++) begin
            tv = (r == 0) ? 32'd3 : 32'($urandom_range(1, 12));
            store(4'd2, 32'h1);
            rd(BASE + 32'd2, v); check("timer_clear", v, exp_status(0, 0, 0, 0));
            store(4'd1, tv);
            for (int k = 0; k <= int'(tv) + 2; k++) begin
                rd(BASE + 32'd1, v);
                check("timer_val", v, (k < int'(tv)) ? tv - 32'(k) : 32'd0);
                rd(BASE + 32'd2, v);
                check("timer_done", {31'd0, v[0]}, {31'd0, k >= int'(tv)});
                tick();
            end
        end
        store(4'd2, 32'h1);
        rd(BASE + 32'd2, v); check("done_w1c", v, exp_status(0, 0, 0, 0));

        // Store overrides decrement
        store(4'd1, 32'd9);
        tick(); tick();
        store(4'd1, 32'd20);
        rd(BASE + 32'd1, v); check("timer_store_wins", v, 32'd20);
        tick();
        rd(BASE + 32'd1, v); check("timer_after_reload", v, 32'd19);

        // Set beats W1C in the same cycle
        store(4'd1, 32'd2);
        tick();
        store(4'd2, 32'h1);
        rd(BASE + 32'd2, v); check("set_beats_w1c", {31'd0, v[0]}, 32'd1);
        store(4'd2, 32'h1);
        store(4'd1, 32'd0);
        repeat (3) tick();
        rd(BASE + 32'd2, v); check("timer_zero_no_done", v, exp_status(0, 0, 0, 0));

        // Single frames: 0xA5 then a random byte
        for (int r = 0; r < 2; r++) begin
            b = (r == 0) ? 8'hA5 : 8'($urandom);
            store(4'd3, {24'd0, b});
            rd(BASE + 32'd2, v); check("status_one_queued", v, exp_status(0, 0, 1, 0));
            tick();
            check_frame(b);
            check("busy_after_stop", {31'd0, tx_busy}, 32'd0);
            check("tx_idle_high", {31'd0, tx}, 32'd1);
            rd(BASE + 32'd2, v); check("status_idle", v, exp_status(0, 0, 0, 0));
            rd(BASE + 32'd3, v); check("txdata_reads0", v, 32'd0);
        end

        // Fill behind an active frame, overflow, then push+pop on full
        store(4'd3, {24'd0, 8'($urandom)});
        tick();
        p = model_cycle;
        fifo_q.delete();
        ovf_exp = 1'b0;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            if (fifo_q.size() < DEPTH) fifo_q.push_back(b);
            else                       ovf_exp = 1'b1;
            store(4'd3, {24'd0, b});
        end
        rd(BASE + 32'd2, v); check("status_overflow", v, exp_status(0, ovf_exp, fifo_q.size(), 1));
        store(4'd2, 32'h100);
        rd(BASE + 32'd2, v); check("ovf_w1c", v, exp_status(0, 0, fifo_q.size(), 1));
        for (int n = 0; n < 100 && model_cycle != p + 32'd40; n++) tick();
        b2 = fifo_q.pop_front();
        b  = 8'($urandom);
        fifo_q.push_back(b);
        store(4'd3, {24'd0, b});
        rd(BASE + 32'd2, v); check("push_pop_full", v, exp_status(0, 0, fifo_q.size(), 1));
        check_frame(b2);
        while (fifo_q.size() > 0) begin
            tick();
            check_frame(fifo_q.pop_front());
        end
        check("busy_drained", {31'd0, tx_busy}, 32'd0);

        // Decode window edges
        store(4'd1, 32'd500);
        rd(BASE + 32'd17, v);
        check("sel_outside", {31'd0, sel}, 32'd0);
        check("read_outside", v, 32'd0);
        store_addr(BASE + 32'd17, 32'd7);
        store_addr(BASE + 32'd19, 32'h55);
        rd(BASE + 32'd1, v); check("outside_store_ignored", v, 32'd498);
        check("outside_tx_ignored", {31'd0, tx_busy}, 32'd0);
        rd(BASE + 32'd7, v);
        check("sel_inside", {31'd0, sel}, 32'd1);
        check("read_off7", v, 32'd0);
        store_addr(BASE + 32'd7, 32'hFFFF_FFFF);
        rd(BASE + 32'd2, v); check("off7_store_ignored", v, exp_status(0, 0, 0, 0));

        // Asynchronous reset in the middle of a data bit
        store(4'd3, {24'd0, 8'($urandom)});
        store(4'd3, {24'd0, 8'($urandom)});
        repeat (3 * BD) tick();
        #2;
        reset = 1'b1;
        #1;
        check("midframe_rst_tx", {31'd0, tx}, 32'd1);
        check("midframe_rst_busy", {31'd0, tx_busy}, 32'd0);
        rd(BASE + 32'd2, v); check("midframe_rst_status", v, 32'h4);
        rd(BASE + 32'd1, v); check("midframe_rst_timer", v, 32'd0);
        rd(BASE + 32'd0, v); check("midframe_rst_cycle", v, 32'd0);
        reset       = 1'b0;
        model_cycle = '0;
        tick();
        rd(BASE, v); check("cycle_after_rst", v, model_cycle);
        check("tx_after_rst", {31'd0, tx}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
